mux2t1_32: RTL and testbench

// - 2-to-1 word multiplexer for CPU datapath operand/PC/writeback selection.
// - Primary output o is purely combinational: o = sel ? I1 : I0, with no clock dependency.
// - Adds a registered copy of the selected word plus a change flag for timing-closed consumers
//   and debug taps.

---
 rtl/mux2t1_32_pkg.sv | 7 +
 rtl/mux2t1_32.sv | 56 +++++
 tb/tb_mux2t1_32.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux2t1_32_pkg.sv
// Shared datapath constants for the CPU word multiplexer.
package mux2t1_32_pkg;

    // Native datapath word width.
    localparam int unsigned DATA_WIDTH = 32;

endpackage : mux2t1_32_pkg

// File: rtl/mux2t1_32.sv
// 2-to-1 word multiplexer with a zero-latency combinational output plus a
// registered copy of the selected word, the registered select, and a one-cycle
// change pulse for timing-closed consumers and debug taps.
module mux2t1_32
    import mux2t1_32_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             sel,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_r,
    output logic             sel_r,
    output logic             chg
);

    logic [WIDTH-1:0] o_r_d;
    logic [WIDTH-1:0] o_r_q;
    logic             sel_r_d;
    logic             sel_r_q;
    logic             chg_d;
    logic             chg_q;

    // Ternary kept as a continuous assign so an unknown sel merges I0/I1
    // bitwise (X only where they differ) and o never depends on clk or rst.
    assign o = sel ? I1 : I0;

    // Next-state: capture the current selection and flag a change against
    // the value currently held in o_r.
    always_comb begin
        o_r_d   = o;
        sel_r_d = sel;
        chg_d   = (o != o_r_q);
    end

    // Registered copies, cleared immediately while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_r_q   <= '0;
            sel_r_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            o_r_q   <= o_r_d;
            sel_r_q <= sel_r_d;
            chg_q   <= chg_d;
        end
    end

    assign o_r   = o_r_q;
    assign sel_r = sel_r_q;
    assign chg   = chg_q;

endmodule : mux2t1_32

// File: tb/tb_mux2t1_32.sv
// Self-checking bench for mux2t1_32: directed scenarios plus randomized
// stimulus compared against a behavioural model of the registered path.
module tb_mux2t1_32;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] I0;
    logic [W-1:0] I1;
    logic         sel;
    logic [W-1:0] o;
    logic [W-1:0] o_r;
    logic         sel_r;
    logic         chg;

    int total;
    int bad;

    // Behavioural model state: what the registered outputs should hold.
    logic [W-1:0] m_or;
    logic         m_sel;
    logic         m_chg;

    mux2t1_32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .I0    (I0),
        .I1    (I1),
        .sel   (sel),
        .o     (o),
        .o_r   (o_r),
        .sel_r (sel_r),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the selection: pick a word out of a two-entry table.
    function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        logic [W-1:0] words [2];
        words[0] = a;
        words[1] = b;
        return words[s];
    endfunction

    // Advance the model across one clock edge using the pre-edge inputs,
    // then move to just after the edge for sampling.
    task automatic step();
        logic [W-1:0] cur;
        cur   = pick(I0, I1, sel);
        m_chg = (cur != m_or);
        m_or  = cur;
        m_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        I0  = '0;
        I1  = '0;
        sel = 1'b0;
        #2;
        total++;
        if (o !== 32'h0) begin bad++; $display("FAIL reset_o got=%h exp=%h", o, 32'h0); end
        total++;
        if (o_r !== 32'h0 || sel_r !== 1'b0 || chg !== 1'b0) begin
            bad++; $display("FAIL reset_regs got o_r=%h sel_r=%b chg=%b exp 0/0/0", o_r, sel_r, chg);
        end
        @(posedge clk); #1;
        total++;
        if (o_r !== 32'h0 || sel_r !== 1'b0 || chg !== 1'b0) begin
            bad++; $display("FAIL reset_hold got o_r=%h sel_r=%b chg=%b exp 0/0/0", o_r, sel_r, chg);
        end
        @(negedge clk);
        rst   = 1'b0;
        m_or  = '0;
        m_sel = 1'b0;
        m_chg = 1'b0;
    endtask

    task automatic test_comb();
        @(negedge clk);
        sel = 1'b0;
        I0  = 32'd1;
        I1  = 32'd16;
        #1;
        total++;
        if (o !== 32'd1) begin bad++; $display("FAIL comb_sel0 got=%h exp=%h", o, 32'd1); end
        sel = 1'b1;
        #1;
        total++;
        if (o !== 32'd16) begin bad++; $display("FAIL comb_sel1 got=%h exp=%h", o, 32'd16); end
        I1 = 32'hCAFE0001;
        #1;
        total++;
        if (o !== 32'hCAFE0001) begin bad++; $display("FAIL comb_data got=%h exp=%h", o, 32'hCAFE0001); end
    endtask

    task automatic test_toggle();
        @(negedge clk);
        I0  = 32'hDEADBEEF;
        I1  = 32'h12345678;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (o_r !== m_or || sel_r !== m_sel || chg !== m_chg) begin
                bad++;
                $display("FAIL toggle[%0d] got o_r=%h sel_r=%b chg=%b exp o_r=%h sel_r=%b chg=%b",
                         i, o_r, sel_r, chg, m_or, m_sel, m_chg);
            end
            if (i > 0) begin
                total++;
                if (chg !== 1'b1) begin bad++; $display("FAIL toggle_chg[%0d] got=%b exp=1", i, chg); end
            end
            @(negedge clk);
            sel = ~sel;
        end
    endtask

    task automatic test_equal();
        @(negedge clk);
        I0  = 32'hA5A5A5A5;
        I1  = 32'hA5A5A5A5;
        sel = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sel = ~sel;
            #1;
            total++;
            if (o !== 32'hA5A5A5A5) begin bad++; $display("FAIL equal_o[%0d] got=%h exp=%h", i, o, 32'hA5A5A5A5); end
            step();
            total++;
            if (o_r !== 32'hA5A5A5A5 || chg !== 1'b0 || sel_r !== m_sel) begin
                bad++;
                $display("FAIL equal_reg[%0d] got o_r=%h chg=%b sel_r=%b exp o_r=%h chg=0 sel_r=%b",
                         i, o_r, chg, sel_r, 32'hA5A5A5A5, m_sel);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            I0  = $urandom;
            I1  = ($urandom_range(0, 4) == 0) ? I0 : $urandom;
            sel = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (o !== pick(I0, I1, sel)) begin
                bad++; $display("FAIL rand_o[%0d] got=%h exp=%h", i, o, pick(I0, I1, sel));
            end
            step();
            total++;
            if (o_r !== m_or || sel_r !== m_sel || chg !== m_chg) begin
                bad++;
                $display("FAIL rand_reg[%0d] got o_r=%h sel_r=%b chg=%b exp o_r=%h sel_r=%b chg=%b",
                         i, o_r, sel_r, chg, m_or, m_sel, m_chg);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        I0  = 32'h0BADF00D;
        I1  = 32'h76543210;
        sel = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (o_r !== 32'h0 || sel_r !== 1'b0 || chg !== 1'b0) begin
            bad++; $display("FAIL midrst_regs got o_r=%h sel_r=%b chg=%b exp 0/0/0", o_r, sel_r, chg);
        end
        total++;
        if (o !== 32'h76543210) begin bad++; $display("FAIL midrst_o got=%h exp=%h", o, 32'h76543210); end
        sel = 1'b0;
        @(posedge clk); #1;
        total++;
        if (o_r !== 32'h0 || sel_r !== 1'b0 || chg !== 1'b0 || o !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL midrst_hold got o=%h o_r=%h sel_r=%b chg=%b exp o=%h 0/0/0",
                     o, o_r, sel_r, chg, 32'h0BADF00D);
        end
        @(negedge clk);
        rst   = 1'b0;
        m_or  = '0;
        m_sel = 1'b0;
        step();
        total++;
        if (o_r !== 32'h0BADF00D || chg !== 1'b1 || sel_r !== 1'b0 || m_chg !== 1'b1) begin
            bad++;
            $display("FAIL midrst_release got o_r=%h chg=%b sel_r=%b exp o_r=%h chg=1 sel_r=0",
                     o_r, chg, sel_r, 32'h0BADF00D);
        end
    endtask

    task automatic test_xsel();
        logic [W-1:0] agree;
        @(negedge clk);
        I0    = 32'h0000FFFF;
        I1    = 32'h0000F0F0;
        sel   = 1'bx;
        agree = ~(I0 ^ I1);
        #1;
        total++;
        if ((o & agree) !== (I0 & agree)) begin
            bad++; $display("FAIL xsel_common got=%h exp=%h", o & agree, I0 & agree);
        end
        total++;
        if (o[31:16] !== 16'h0000) begin bad++; $display("FAIL xsel_upper got=%h exp=%h", o[31:16], 16'h0000); end
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_comb();
        test_toggle();
        test_equal();
        test_random();
        test_reset_mid();
        test_xsel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux2t1_32
